// File: rtl/cpu_pkg.sv
// Shared encodings for the Fibonacci core: PC/WB select codes, opcodes,
// control FSM states and the instruction-class decode used by the control unit.
package cpu_pkg;

    // Next-PC select
    localparam logic [1:0] PC_4      = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JAL    = 2'b10;
    localparam logic [1:0] PC_HOLD   = 2'b11;

    // Writeback source select
    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;

    // Opcodes (instr[6:0])
    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_ECALL  = 7'b1110011;

    // Memory-wait watchdog counter width
    localparam int WDOG_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_e;

    typedef enum logic [2:0] {
        OP_R,
        OP_I,
        OP_LOAD,
        OP_STORE,
        OP_BRANCH,
        OP_JAL,
        OP_ECALL,
        OP_ILLEGAL
    } op_class_e;

    // Map a raw opcode onto the instruction class the FSM sequences by.
    function automatic op_class_e classify_opcode(input logic [6:0] opc);
        op_class_e cls;
        case (opc)
            OPC_R:      cls = OP_R;
            OPC_I:      cls = OP_I;
            OPC_LOAD:   cls = OP_LOAD;
            OPC_STORE:  cls = OP_STORE;
            OPC_BRANCH: cls = OP_BRANCH;
            OPC_JAL:    cls = OP_JAL;
            OPC_ECALL:  cls = OP_ECALL;
            default:    cls = OP_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/mcu_watchdog.sv
// Wait-cycle watchdog: counts cycles spent waiting on a memory handshake and
// flags expiry once the count reaches TIMEOUT_CYC.
module mcu_watchdog
    import cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic arst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    logic [WDOG_W-1:0] r_count;

    assign o_expired = (r_count == WDOG_W'(TIMEOUT_CYC));

    // Count wait cycles; a clear (state change) always wins, and the count
    // parks at the limit so it can never wrap back to zero.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + WDOG_W'(1);
        end
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM for the Fibonacci core: sequences fetch, decode,
// execute, memory and writeback for one instruction at a time, and drives
// PC/IR/register-file enables, memory requests and datapath mux selects.
module multicycle_control_unit
    import cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        run,
    input  logic [6:0]  opcode,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        pc_write,
    output logic [1:0]  pc_sel,
    output logic        ir_write,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        alu_src_imm,
    output logic        alu_sub,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic [31:0] instret,
    output logic        halted,
    output logic        fault
);

    state_e      r_state;
    state_e      w_next_state;
    op_class_e   r_op;
    op_class_e   w_dec_op;
    logic        r_fault;
    logic [31:0] r_instret;
    logic        w_set_fault;
    logic        w_expired;
    logic        w_wdog_clear;
    logic        w_wdog_en;

    assign w_dec_op     = classify_opcode(opcode);
    assign w_wdog_clear = (w_next_state != r_state);
    assign w_wdog_en    = (r_state == S_FETCH) || (r_state == S_MEM);

    assign instret = r_instret;
    assign halted  = (r_state == S_HALT);
    assign fault   = r_fault;

    mcu_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk       (clk),
        .arst_n    (arst_n),
        .i_clear   (w_wdog_clear),
        .i_enable  (w_wdog_en),
        .o_expired (w_expired)
    );

    // State register, latched instruction class, sticky fault and retire counter.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state   <= S_IDLE;
            r_op      <= OP_ILLEGAL;
            r_fault   <= 1'b0;
            r_instret <= '0;
        end else begin
            r_state <= w_next_state;
            // The class is captured once in DECODE so later states never
            // depend on the IR output again (e.g. while stalled in MEM).
            if (r_state == S_DECODE) begin
                r_op <= w_dec_op;
            end
            if (w_set_fault) begin
                r_fault <= 1'b1;
            end
            if (pc_write) begin
                r_instret <= r_instret + 32'd1;
            end
        end
    end

    // Next-state and control-output decode from the current state.
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_set_fault  = 1'b0;
        pc_write     = 1'b0;
        pc_sel       = PC_HOLD;
        ir_write     = 1'b0;
        imem_req     = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        alu_src_imm  = 1'b0;
        alu_sub      = 1'b0;
        reg_write    = 1'b0;
        wb_sel       = WB_ALU;

        case (r_state)
            S_IDLE: begin
                if (run) begin
                    w_next_state = S_FETCH;
                end
            end

            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    // Ready in the same cycle as expiry still completes the fetch.
                    ir_write     = 1'b1;
                    w_next_state = S_DECODE;
                end else if (w_expired) begin
                    w_set_fault  = 1'b1;
                    w_next_state = S_HALT;
                end
            end

            S_DECODE: begin
                case (w_dec_op)
                    OP_ECALL:   w_next_state = S_HALT;
                    OP_ILLEGAL: begin
                        w_set_fault  = 1'b1;
                        w_next_state = S_HALT;
                    end
                    default:    w_next_state = S_EXEC;
                endcase
            end

            S_EXEC: begin
                case (r_op)
                    OP_R: w_next_state = S_WB;
                    OP_I: begin
                        alu_src_imm  = 1'b1;
                        w_next_state = S_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src_imm  = 1'b1;
                        w_next_state = S_MEM;
                    end
                    OP_BRANCH: begin
                        alu_sub      = 1'b1;
                        pc_sel       = PC_BRANCH;
                        pc_write     = 1'b1;
                        w_next_state = S_FETCH;
                    end
                    OP_JAL: begin
                        pc_sel       = PC_JAL;
                        pc_write     = 1'b1;
                        reg_write    = 1'b1;
                        wb_sel       = WB_PC4;
                        w_next_state = S_FETCH;
                    end
                    default: begin
                        // Not reachable: DECODE never forwards ECALL/illegal here.
                        w_set_fault  = 1'b1;
                        w_next_state = S_HALT;
                    end
                endcase
            end

            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (r_op == OP_STORE);
                if (dmem_ready) begin
                    if (r_op == OP_STORE) begin
                        pc_write     = 1'b1;
                        pc_sel       = PC_4;
                        w_next_state = S_FETCH;
                    end else begin
                        w_next_state = S_WB;
                    end
                end else if (w_expired) begin
                    w_set_fault  = 1'b1;
                    w_next_state = S_HALT;
                end
            end

            S_WB: begin
                reg_write    = 1'b1;
                wb_sel       = (r_op == OP_LOAD) ? WB_LOAD : WB_ALU;
                pc_write     = 1'b1;
                pc_sel       = PC_4;
                w_next_state = S_FETCH;
            end

            S_HALT: begin
                w_next_state = S_HALT;
            end

            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed testbench for multicycle_control_unit. Control outputs are packed
// into one vector and compared per cycle against hand-derived expectations.
module tb_multicycle_control_unit;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        run;
    logic [6:0]  opcode;
    logic        imem_ready;
    logic        dmem_ready;
    logic        pc_write;
    logic [1:0]  pc_sel;
    logic        ir_write;
    logic        imem_req;
    logic        dmem_req;
    logic        dmem_we;
    logic        alu_src_imm;
    logic        alu_sub;
    logic        reg_write;
    logic [1:0]  wb_sel;
    logic [31:0] instret;
    logic        halted;
    logic        fault;

    int n_tests = 0;
    int n_fail  = 0;

    // {pc_write, pc_sel, ir_write, imem_req, dmem_req, dmem_we,
    //  alu_src_imm, alu_sub, reg_write, wb_sel, halted, fault}
    wire [13:0] w_obs = {pc_write, pc_sel, ir_write, imem_req, dmem_req, dmem_we,
                         alu_src_imm, alu_sub, reg_write, wb_sel, halted, fault};

    localparam logic [13:0] V_QUIET      = 14'b0_11_0_0_0_0_0_0_0_00_0_0;
    localparam logic [13:0] V_FETCH_RDY  = 14'b0_11_1_1_0_0_0_0_0_00_0_0;
    localparam logic [13:0] V_FETCH_WAIT = 14'b0_11_0_1_0_0_0_0_0_00_0_0;
    localparam logic [13:0] V_EXEC_IMM   = 14'b0_11_0_0_0_0_1_0_0_00_0_0;
    localparam logic [13:0] V_EXEC_BEQ   = 14'b1_01_0_0_0_0_0_1_0_00_0_0;
    localparam logic [13:0] V_EXEC_JAL   = 14'b1_10_0_0_0_0_0_0_1_10_0_0;
    localparam logic [13:0] V_MEM_LD     = 14'b0_11_0_0_1_0_0_0_0_00_0_0;
    localparam logic [13:0] V_MEM_ST_W   = 14'b0_11_0_0_1_1_0_0_0_00_0_0;
    localparam logic [13:0] V_MEM_ST_R   = 14'b1_00_0_0_1_1_0_0_0_00_0_0;
    localparam logic [13:0] V_WB_ALU     = 14'b1_00_0_0_0_0_0_0_1_00_0_0;
    localparam logic [13:0] V_WB_LD      = 14'b1_00_0_0_0_0_0_0_1_01_0_0;
    localparam logic [13:0] V_HALT_F     = 14'b0_11_0_0_0_0_0_0_0_00_1_1;
    localparam logic [13:0] V_HALT_OK    = 14'b0_11_0_0_0_0_0_0_0_00_1_0;

    multicycle_control_unit dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .run         (run),
        .opcode      (opcode),
        .imem_ready  (imem_ready),
        .dmem_ready  (dmem_ready),
        .pc_write    (pc_write),
        .pc_sel      (pc_sel),
        .ir_write    (ir_write),
        .imem_req    (imem_req),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .alu_src_imm (alu_src_imm),
        .alu_sub     (alu_sub),
        .reg_write   (reg_write),
        .wb_sel      (wb_sel),
        .instret     (instret),
        .halted      (halted),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        arst_n     = 1'b0;
        run        = 1'b0;
        opcode     = 7'd0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        cyc();
        cyc();
        arst_n = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            #1;
            n_tests++;
            if (w_obs !== V_QUIET) begin
                n_fail++;
                $display("FAIL reset_idle cycle %0d: outputs %b, expected %b", i, w_obs, V_QUIET);
            end
            cyc();
        end
        n_tests++;
        if (instret !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_instret: got %0d, expected 0", instret);
        end
    endtask

    task automatic test_addi();
        logic [13:0] exp [6];
        logic [0:5]  imr;
        exp = '{V_QUIET, V_FETCH_RDY, V_QUIET, V_EXEC_IMM, V_WB_ALU, V_FETCH_WAIT};
        imr = 6'b010000;
        do_reset();
        opcode = OPC_I;
        for (int i = 0; i < 6; i++) begin
            run        = (i == 0);
            imem_ready = imr[i];
            #1;
            n_tests++;
            if (w_obs !== exp[i]) begin
                n_fail++;
                $display("FAIL addi cycle %0d: outputs %b, expected %b", i, w_obs, exp[i]);
            end
            cyc();
        end
        n_tests++;
        if (instret !== 32'd1) begin
            n_fail++;
            $display("FAIL addi_instret: got %0d, expected 1", instret);
        end
    endtask

    task automatic test_branch();
        logic [13:0] exp [5];
        logic [0:4]  imr;
        exp = '{V_QUIET, V_FETCH_RDY, V_QUIET, V_EXEC_BEQ, V_FETCH_WAIT};
        imr = 5'b01000;
        do_reset();
        opcode = OPC_BRANCH;
        for (int i = 0; i < 5; i++) begin
            run        = (i == 0);
            imem_ready = imr[i];
            #1;
            n_tests++;
            if (w_obs !== exp[i]) begin
                n_fail++;
                $display("FAIL beq cycle %0d: outputs %b, expected %b", i, w_obs, exp[i]);
            end
            cyc();
        end
        n_tests++;
        if (instret !== 32'd1) begin
            n_fail++;
            $display("FAIL beq_instret: got %0d, expected 1", instret);
        end
    endtask

    task automatic test_jal();
        logic [13:0] exp [5];
        logic [0:4]  imr;
        exp = '{V_QUIET, V_FETCH_RDY, V_QUIET, V_EXEC_JAL, V_FETCH_WAIT};
        imr = 5'b01000;
        do_reset();
        opcode = OPC_JAL;
        for (int i = 0; i < 5; i++) begin
            run        = (i == 0);
            imem_ready = imr[i];
            #1;
            n_tests++;
            if (w_obs !== exp[i]) begin
                n_fail++;
                $display("FAIL jal cycle %0d: outputs %b, expected %b", i, w_obs, exp[i]);
            end
            cyc();
        end
    endtask

    // Load with dmem_ready three cycles late; opcode input is changed to a
    // store while waiting, which must not affect the in-flight load.
    task automatic test_load_delayed();
        logic [13:0] exp [10];
        logic [0:9]  imr;
        logic [0:9]  dmr;
        exp = '{V_QUIET, V_FETCH_RDY, V_QUIET, V_EXEC_IMM, V_MEM_LD,
                V_MEM_LD, V_MEM_LD, V_MEM_LD, V_WB_LD, V_FETCH_WAIT};
        imr = 10'b0100000000;
        dmr = 10'b0000000100;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            run        = (i == 0);
            opcode     = (i >= 4) ? OPC_STORE : OPC_LOAD;
            imem_ready = imr[i];
            dmem_ready = dmr[i];
            #1;
            n_tests++;
            if (w_obs !== exp[i]) begin
                n_fail++;
                $display("FAIL load cycle %0d: outputs %b, expected %b", i, w_obs, exp[i]);
            end
            cyc();
        end
        n_tests++;
        if (instret !== 32'd1) begin
            n_fail++;
            $display("FAIL load_instret: got %0d, expected 1", instret);
        end
    endtask

    task automatic test_store();
        logic [13:0] exp [7];
        logic [0:6]  imr;
        logic [0:6]  dmr;
        exp = '{V_QUIET, V_FETCH_RDY, V_QUIET, V_EXEC_IMM, V_MEM_ST_W, V_MEM_ST_R, V_FETCH_WAIT};
        imr = 7'b0100000;
        dmr = 7'b0000010;
        do_reset();
        opcode = OPC_STORE;
        for (int i = 0; i < 7; i++) begin
            run        = (i == 0);
            imem_ready = imr[i];
            dmem_ready = dmr[i];
            #1;
            n_tests++;
            if (w_obs !== exp[i]) begin
                n_fail++;
                $display("FAIL store cycle %0d: outputs %b, expected %b", i, w_obs, exp[i]);
            end
            cyc();
        end
    endtask

    // R-type immediately followed by BEQ.
    task automatic test_back_to_back();
        logic [13:0] exp [9];
        logic [0:8]  imr;
        exp = '{V_QUIET, V_FETCH_RDY, V_QUIET, V_QUIET, V_WB_ALU,
                V_FETCH_RDY, V_QUIET, V_EXEC_BEQ, V_FETCH_WAIT};
        imr = 9'b010001000;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            run        = (i == 0);
            opcode     = (i < 5) ? OPC_R : OPC_BRANCH;
            imem_ready = imr[i];
            #1;
            n_tests++;
            if (w_obs !== exp[i]) begin
                n_fail++;
                $display("FAIL b2b cycle %0d: outputs %b, expected %b", i, w_obs, exp[i]);
            end
            cyc();
        end
        n_tests++;
        if (instret !== 32'd2) begin
            n_fail++;
            $display("FAIL b2b_instret: got %0d, expected 2", instret);
        end
    endtask

    task automatic test_halt_opcode(input logic [6:0] opc, input logic [13:0] halt_vec);
        logic [13:0] exp [5];
        logic [0:4]  imr;
        exp = '{V_QUIET, V_FETCH_RDY, V_QUIET, halt_vec, halt_vec};
        imr = 5'b01000;
        do_reset();
        opcode = opc;
        for (int i = 0; i < 5; i++) begin
            run        = (i == 0) || (i == 4);
            imem_ready = imr[i];
            #1;
            n_tests++;
            if (w_obs !== exp[i]) begin
                n_fail++;
                $display("FAIL halt_opc %b cycle %0d: outputs %b, expected %b", opc, i, w_obs, exp[i]);
            end
            cyc();
        end
    endtask

    // imem_ready never arrives: 255 waited cycles then HALT with fault.
    task automatic test_fetch_timeout();
        do_reset();
        opcode = OPC_I;
        run    = 1'b1;
        cyc();
        run = 1'b0;
        for (int k = 0; k < 256; k++) begin
            if (k == 255) begin
                #1;
                n_tests++;
                if (w_obs !== V_FETCH_WAIT) begin
                    n_fail++;
                    $display("FAIL timeout_last_wait: outputs %b, expected %b", w_obs, V_FETCH_WAIT);
                end
            end
            cyc();
        end
        #1;
        n_tests++;
        if (w_obs !== V_HALT_F) begin
            n_fail++;
            $display("FAIL timeout_halt: outputs %b, expected %b", w_obs, V_HALT_F);
        end
        run        = 1'b1;
        imem_ready = 1'b1;
        repeat (3) cyc();
        n_tests++;
        if (w_obs !== V_HALT_F || instret !== 32'd0) begin
            n_fail++;
            $display("FAIL halt_sticky: outputs %b instret %0d, expected %b instret 0",
                     w_obs, instret, V_HALT_F);
        end
    endtask

    // imem_ready lands on the same cycle the watchdog reaches its limit.
    task automatic test_timeout_ready_wins();
        do_reset();
        opcode = OPC_I;
        run    = 1'b1;
        cyc();
        run = 1'b0;
        repeat (255) cyc();
        imem_ready = 1'b1;
        #1;
        n_tests++;
        if (w_obs !== V_FETCH_RDY) begin
            n_fail++;
            $display("FAIL ready_wins_fetch: outputs %b, expected %b", w_obs, V_FETCH_RDY);
        end
        cyc();
        imem_ready = 1'b0;
        #1;
        n_tests++;
        if (w_obs !== V_QUIET) begin
            n_fail++;
            $display("FAIL ready_wins_decode: outputs %b, expected %b", w_obs, V_QUIET);
        end
    endtask

    // Asynchronous reset while waiting in MEM aborts with no PC update.
    task automatic test_reset_in_mem();
        do_reset();
        opcode = OPC_LOAD;
        run    = 1'b1;
        cyc();
        run        = 1'b0;
        imem_ready = 1'b1;
        cyc();
        imem_ready = 1'b0;
        cyc();
        cyc();
        #1;
        n_tests++;
        if (w_obs !== V_MEM_LD) begin
            n_fail++;
            $display("FAIL rst_mem_pre: outputs %b, expected %b", w_obs, V_MEM_LD);
        end
        dmem_ready = 1'b1;
        arst_n     = 1'b0;
        #1;
        n_tests++;
        if (w_obs !== V_QUIET) begin
            n_fail++;
            $display("FAIL rst_mem_async: outputs %b, expected %b", w_obs, V_QUIET);
        end
        cyc();
        arst_n     = 1'b1;
        dmem_ready = 1'b0;
        #1;
        n_tests++;
        if (w_obs !== V_QUIET || instret !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_mem_after: outputs %b instret %0d, expected %b instret 0",
                     w_obs, instret, V_QUIET);
        end
        cyc();
        n_tests++;
        if (w_obs !== V_QUIET) begin
            n_fail++;
            $display("FAIL rst_mem_idle: outputs %b, expected %b", w_obs, V_QUIET);
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_branch();
        test_jal();
        test_load_delayed();
        test_store();
        test_back_to_back();
        test_halt_opcode(7'b1111111, V_HALT_F);
        test_halt_opcode(OPC_ECALL, V_HALT_OK);
        test_fetch_timeout();
        test_timeout_ready_wins();
        test_reset_in_mem();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
